// File: rtl/cc_interleave.sv
// cc_interleave: 802.16 OFDM two-step block bit interleaver with ping-pong bit banks.
// Serial coded bits in; each completed block streams out serially in interleaved order.
module cc_interleave #(
    parameter int ncbps  = 768,
    parameter int ncpc   = 4,
    parameter int d      = 12,
    parameter int addr_w = $clog2(ncbps)
) (
    input  logic clk,
    input  logic reset,
    input  logic cur_in,
    input  logic valid_in,
    output logic z,
    output logic valid_out,
    output logic blk_last
);
    localparam int s  = (ncpc + 1) / 2;
    localparam int RW = $clog2(d);
    localparam logic [addr_w-1:0] COLS   = addr_w'(ncbps / d);
    localparam logic [addr_w-1:0] S_A    = addr_w'(s);
    localparam logic [addr_w-1:0] LAST   = addr_w'(ncbps - 1);
    localparam logic [addr_w-1:0] Q_LAST = addr_w'(ncbps / d - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(d - 1);
    logic [ncbps-1:0]  r_bank [2];
    logic              r_wsel;
    logic              r_rd_busy;
    logic [RW-1:0]     r_r;
    logic [addr_w-1:0] r_q;
    logic [addr_w-1:0] r_n;
    logic [addr_w-1:0] w_m;
    logic [addr_w-1:0] w_j;
    logic              w_blk_done;
    logic              w_rd_last;
    // floor(12m/ncbps) equals r, so the second permutation needs no divider beyond constant s
    always_comb begin
        w_m        = COLS * addr_w'(r_r) + r_q;
        w_j        = S_A * (w_m / S_A) + (w_m - addr_w'(r_r)) % S_A;
        w_blk_done = valid_in && r_r == R_LAST && r_q == Q_LAST;
        w_rd_last  = r_rd_busy && r_n == LAST;
    end
    always_ff @(posedge clk) begin
        if (valid_in) r_bank[r_wsel][w_j] <= cur_in;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wsel    <= 1'b0;
            r_rd_busy <= 1'b0;
            r_r       <= '0;
            r_q       <= '0;
            r_n       <= '0;
            z         <= 1'b0;
            valid_out <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            z         <= r_rd_busy & r_bank[~r_wsel][r_n];
            valid_out <= r_rd_busy;
            blk_last  <= w_rd_last;
            if (r_rd_busy) r_n <= r_n + addr_w'(1);
            if (w_rd_last) r_rd_busy <= 1'b0;
            if (valid_in) begin
                r_r <= (r_r == R_LAST) ? '0 : r_r + RW'(1);
                r_q <= (r_r == R_LAST) ? r_q + addr_w'(1) : r_q;
            end
            // a completing block wins over read-end so back-to-back blocks stream without a bubble
            if (w_blk_done) begin
                r_r       <= '0;
                r_q       <= '0;
                r_wsel    <= ~r_wsel;
                r_rd_busy <= 1'b1;
                r_n       <= '0;
            end
        end
    end
endmodule
